bscan_spi_framer: RTL and testbench

BSCAN_SPI_FRAMER -- requirements
Module: bscan_spi_framer

---
 rtl/bscan_spi_framer_if.sv | 40 ++++
 rtl/bscan_spi_framer.sv | 161 ++++++++++++++++
 tb/tb_bscan_spi_framer.sv | 359 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bscan_spi_framer_if.sv
// bscan_spi_framer_if
//   Groups the JTAG USER1 tap-side signals and the SPI / readback-RAM
//   outputs of the BSCAN-to-SPI framer.
//   master : the TAP side (drives TAP_RESET, SEL1, SHIFT, CAPTURE, TDI).
//   slave  : the framer (drives CSB, MOSI, WR_EN, WR_ADDR, LEN, BUSY,
//            DONE, LEN_ERR, ABORT and the dbg_state debug view).
//   Handshake: there is no valid/ready pair. A bit is transferred exactly
//   when SEL1 and SHIFT are both high at a rising DRCK1 edge; with either
//   low, nothing advances.
interface bscan_spi_framer_if #(
  parameter int AW = 14
);
  logic          TAP_RESET;
  logic          SEL1;
  logic          SHIFT;
  logic          CAPTURE;
  logic          TDI;
  logic          CSB;
  logic          MOSI;
  logic          WR_EN;
  logic [AW-1:0] WR_ADDR;
  logic [15:0]   LEN;
  logic          BUSY;
  logic          DONE;
  logic          LEN_ERR;
  logic          ABORT;
  logic [1:0]    dbg_state;

  modport master (
    output TAP_RESET, SEL1, SHIFT, CAPTURE, TDI,
    input  CSB, MOSI, WR_EN, WR_ADDR, LEN, BUSY, DONE, LEN_ERR, ABORT,
           dbg_state
  );

  modport slave (
    input  TAP_RESET, SEL1, SHIFT, CAPTURE, TDI,
    output CSB, MOSI, WR_EN, WR_ADDR, LEN, BUSY, DONE, LEN_ERR, ABORT,
           dbg_state
  );
endinterface

// File: rtl/bscan_spi_framer.sv
// bscan_spi_framer
//   Hunts the USER1 data-register stream for a 48-bit header
//   (32-bit MAGIC sync word, then a 16-bit bit count, both LSB first),
//   then opens the SPI flash chip select for exactly that many shift
//   cycles. Every transferred bit also produces one readback RAM write.
// Ports
//   DRCK1   : sole clock, rising edge.
//   RESET_N : asynchronous active-low reset.
//   bus     : bscan_spi_framer_if.slave (TAP inputs, SPI/RAM outputs,
//             dbg_state = current FSM state).
module bscan_spi_framer #(
  parameter logic [31:0] MAGIC   = 32'h59A659A6,
  parameter int          AW      = 14,
  parameter int          MAX_LEN = 16384
) (
  input  logic                   DRCK1,
  input  logic                   RESET_N,
  bscan_spi_framer_if.slave      bus
);

  localparam logic [1:0] ST_HUNT = 2'd0;
  localparam logic [1:0] ST_XFER = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [16:0] MAX_LEN_W = 17'(MAX_LEN);

  logic [1:0]    state_q, state_d;
  logic [47:0]   header_q, header_d;
  logic [15:0]   len_q, len_d;
  logic [15:0]   remaining_q, remaining_d;
  logic          csb_q, csb_d;
  logic          wr_en_q, wr_en_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic          len_err_q, len_err_d;
  logic          abort_q, abort_d;

  logic          shift_cyc;
  logic [47:0]   hdr_shifted;
  logic [15:0]   req_len;
  logic          too_long;
  logic          hdr_match;
  logic [15:0]   len_clamped;

  always_comb begin
    shift_cyc   = bus.SEL1 & bus.SHIFT;
    hdr_shifted = {bus.TDI, header_q[47:1]};
    req_len     = hdr_shifted[47:32];
    too_long    = {1'b0, req_len} > MAX_LEN_W;
    len_clamped = too_long ? MAX_LEN_W[15:0] : req_len;
    // The match is judged on the value the register will hold after this
    // shift, so the transfer can start on the very edge the header lands.
    hdr_match   = shift_cyc && (hdr_shifted[31:0] == MAGIC);
  end

  always_comb begin
    state_d     = state_q;
    header_d    = header_q;
    len_d       = len_q;
    remaining_d = remaining_q;
    csb_d       = csb_q;
    wr_en_d     = 1'b0;
    abort_d     = 1'b0;
    len_err_d   = len_err_q;
    // The address steps once the write strobe has been presented.
    wr_addr_d   = wr_en_q ? wr_addr_q + 1'b1 : wr_addr_q;

    if (bus.TAP_RESET) begin
      // Wins over anything else, including a header match on this edge.
      state_d  = ST_HUNT;
      csb_d    = 1'b1;
      header_d = '0;
      abort_d  = (state_q == ST_XFER);
    end else begin
      case (state_q)
        ST_HUNT: begin
          if (shift_cyc) begin
            header_d = hdr_shifted;
            if (hdr_match) begin
              len_d = len_clamped;
              if (too_long) begin
                len_err_d = 1'b1;
              end else if (req_len != 16'd0) begin
                len_err_d = 1'b0;
              end
              if (req_len == 16'd0) begin
                state_d = ST_DONE;
              end else begin
                state_d     = ST_XFER;
                csb_d       = 1'b0;
                remaining_d = len_clamped;
                wr_addr_d   = '0;
              end
            end
          end
        end
        ST_XFER: begin
          if (bus.CAPTURE || !bus.SEL1) begin
            state_d  = ST_HUNT;
            csb_d    = 1'b1;
            header_d = '0;
            abort_d  = 1'b1;
          end else if (bus.SHIFT) begin
            remaining_d = remaining_q - 16'd1;
            wr_en_d     = 1'b1;
            if (remaining_q == 16'd1) begin
              // Last bit: deselect on the same edge that consumes it.
              csb_d   = 1'b1;
              state_d = ST_DONE;
            end
          end
        end
        ST_DONE: begin
          if (bus.CAPTURE || !bus.SEL1) begin
            state_d  = ST_HUNT;
            header_d = '0;
          end
        end
        default: begin
          state_d = ST_HUNT;
          csb_d   = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge DRCK1 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= ST_HUNT;
      header_q    <= '0;
      len_q       <= '0;
      remaining_q <= '0;
      csb_q       <= 1'b1;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      len_err_q   <= 1'b0;
      abort_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      header_q    <= header_d;
      len_q       <= len_d;
      remaining_q <= remaining_d;
      csb_q       <= csb_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      len_err_q   <= len_err_d;
      abort_q     <= abort_d;
    end
  end

  assign bus.CSB       = csb_q;
  assign bus.MOSI      = bus.TDI;
  assign bus.WR_EN     = wr_en_q;
  assign bus.WR_ADDR   = wr_addr_q;
  assign bus.LEN       = len_q;
  assign bus.BUSY      = (state_q == ST_XFER);
  assign bus.DONE      = (state_q == ST_DONE);
  assign bus.LEN_ERR   = len_err_q;
  assign bus.ABORT     = abort_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_bscan_spi_framer.sv
module tb_bscan_spi_framer;

  localparam int          AW      = 14;
  localparam int          MAX_LEN = 16384;
  localparam logic [31:0] MAGIC   = 32'h59A659A6;

  logic DRCK1;
  logic RESET_N;

  bscan_spi_framer_if #(.AW(AW)) bus();

  bscan_spi_framer #(.MAGIC(MAGIC), .AW(AW), .MAX_LEN(MAX_LEN)) dut (
    .DRCK1   (DRCK1),
    .RESET_N (RESET_N),
    .bus     (bus)
  );

  // ---------------- clock / reset ----------------
  initial DRCK1 = 1'b0;
  always #5 DRCK1 = ~DRCK1;

  int checks;
  int errors;
  int csb_low_cnt;
  int mosi_err;
  int pause_bad;
  logic [AW-1:0] obs_q[$];
  logic [AW-1:0] exp_q[$];

  // ---------------- reference model ----------------
  // Number of bits the flash sees for a requested length.
  function automatic int model_bits(input int req);
    return (req > MAX_LEN) ? MAX_LEN : req;
  endfunction

  // Expected RAM write addresses: one per bit, counting from 0, mod 2^AW.
  function automatic void model_writes(input int req);
    exp_q.delete();
    for (int i = 0; i < model_bits(req); i++) exp_q.push_back(AW'(i % (1 << AW)));
  endfunction

  function automatic bit writes_match();
    if (obs_q.size() != exp_q.size()) return 1'b0;
    foreach (exp_q[i]) if (obs_q[i] !== exp_q[i]) return 1'b0;
    return 1'b1;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic clear_obs();
    obs_q.delete();
    csb_low_cnt = 0;
  endtask

  // One clock: drive inputs away from the edge, account for CSB before the
  // edge, then record the registered write strobe just after it.
  task automatic step(input logic sel, input logic shift, input logic cap,
                      input logic trst, input logic tdi);
    bus.SEL1      = sel;
    bus.SHIFT     = shift;
    bus.CAPTURE   = cap;
    bus.TAP_RESET = trst;
    bus.TDI       = tdi;
    #1;
    if (sel && shift) begin
      if (bus.CSB === 1'b0) csb_low_cnt++;
      if (bus.MOSI !== tdi) mosi_err++;
    end
    @(posedge DRCK1);
    #1;
    if (bus.WR_EN === 1'b1) obs_q.push_back(bus.WR_ADDR);
  endtask

  task automatic send_header(input logic [15:0] len, input logic trst_last);
    logic [47:0] hdr;
    hdr = {len, MAGIC};
    for (int i = 0; i < 48; i++)
      step(1'b1, 1'b1, 1'b0, (i == 47) ? trst_last : 1'b0, hdr[i]);
  endtask

  task automatic send_data(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'($urandom_range(0, 1)));
  endtask

  task automatic go_hunt();
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    checks++;
    if ({bus.CSB, bus.WR_EN, bus.BUSY, bus.DONE, bus.LEN_ERR, bus.ABORT} !== 6'b100000) begin
      errors++;
      $display("FAIL reset_flags got %b want 100000",
               {bus.CSB, bus.WR_EN, bus.BUSY, bus.DONE, bus.LEN_ERR, bus.ABORT});
    end
    checks++;
    if (bus.WR_ADDR !== '0 || bus.LEN !== 16'd0) begin
      errors++;
      $display("FAIL reset_addr_len got addr=%0d len=%0d want 0/0", bus.WR_ADDR, bus.LEN);
    end
  endtask

  task automatic test_basic();
    clear_obs();
    send_header(16'd8, 1'b0);
    checks++;
    if (bus.BUSY !== 1'b1 || bus.CSB !== 1'b0) begin
      errors++;
      $display("FAIL basic_entry got busy=%b csb=%b want 1/0", bus.BUSY, bus.CSB);
    end
    send_data(8);
    model_writes(8);
    checks++;
    if (csb_low_cnt != model_bits(8)) begin
      errors++;
      $display("FAIL basic_csb_cycles got %0d want %0d", csb_low_cnt, model_bits(8));
    end
    checks++;
    if (!writes_match()) begin
      errors++;
      $display("FAIL basic_writes got %0d writes want %0d (addr 0..7)", obs_q.size(), exp_q.size());
    end
    checks++;
    if (bus.DONE !== 1'b1 || bus.CSB !== 1'b1 || bus.LEN !== 16'd8 || bus.LEN_ERR !== 1'b0) begin
      errors++;
      $display("FAIL basic_end got done=%b csb=%b len=%0d err=%b want 1/1/8/0",
               bus.DONE, bus.CSB, bus.LEN, bus.LEN_ERR);
    end
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (bus.DONE !== 1'b0 || bus.ABORT !== 1'b0 || bus.LEN !== 16'd8) begin
      errors++;
      $display("FAIL done_exit got done=%b abort=%b len=%0d want 0/0/8", bus.DONE, bus.ABORT, bus.LEN);
    end
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_zero_len();
    clear_obs();
    send_header(16'd0, 1'b0);
    send_data(6);
    checks++;
    if (bus.DONE !== 1'b1 || csb_low_cnt != 0 || obs_q.size() != 0 || bus.LEN !== 16'd0) begin
      errors++;
      $display("FAIL zero_len got done=%b csb_low=%0d writes=%0d len=%0d want 1/0/0/0",
               bus.DONE, csb_low_cnt, obs_q.size(), bus.LEN);
    end
    go_hunt();
  endtask

  task automatic test_clamp();
    clear_obs();
    send_header(16'd20000, 1'b0);
    checks++;
    if (bus.LEN !== 16'(MAX_LEN) || bus.LEN_ERR !== 1'b1) begin
      errors++;
      $display("FAIL clamp_len got len=%0d err=%b want %0d/1", bus.LEN, bus.LEN_ERR, MAX_LEN);
    end
    send_data(MAX_LEN + 5);
    model_writes(20000);
    checks++;
    if (csb_low_cnt != model_bits(20000)) begin
      errors++;
      $display("FAIL clamp_csb_cycles got %0d want %0d", csb_low_cnt, model_bits(20000));
    end
    checks++;
    if (!writes_match() || bus.WR_ADDR !== '0) begin
      errors++;
      $display("FAIL clamp_writes got %0d writes final_addr=%0d want %0d/0",
               obs_q.size(), bus.WR_ADDR, exp_q.size());
    end
    go_hunt();
    send_header(16'd0, 1'b0);
    checks++;
    if (bus.LEN_ERR !== 1'b1) begin
      errors++;
      $display("FAIL len_err_sticky got %b want 1", bus.LEN_ERR);
    end
    go_hunt();
    send_header(16'd3, 1'b0);
    send_data(3);
    checks++;
    if (bus.LEN_ERR !== 1'b0 || bus.DONE !== 1'b1) begin
      errors++;
      $display("FAIL len_err_clear got err=%b done=%b want 0/1", bus.LEN_ERR, bus.DONE);
    end
    go_hunt();
  endtask

  task automatic test_pause();
    clear_obs();
    pause_bad = 0;
    send_header(16'd16, 1'b0);
    send_data(4);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'($urandom_range(0, 1)));
      if (bus.CSB !== 1'b0 || bus.WR_EN !== 1'b0 || bus.BUSY !== 1'b1) pause_bad++;
    end
    checks++;
    if (pause_bad != 0) begin
      errors++;
      $display("FAIL pause_hold got %0d bad cycles want 0", pause_bad);
    end
    send_data(12);
    model_writes(16);
    checks++;
    if (csb_low_cnt != 16 || !writes_match() || bus.DONE !== 1'b1) begin
      errors++;
      $display("FAIL pause_total got csb_low=%0d writes=%0d done=%b want 16/16/1",
               csb_low_cnt, obs_q.size(), bus.DONE);
    end
    go_hunt();
  endtask

  task automatic test_abort();
    clear_obs();
    send_header(16'd16, 1'b0);
    send_data(3);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (bus.ABORT !== 1'b1 || bus.CSB !== 1'b1 || bus.BUSY !== 1'b0 || bus.DONE !== 1'b0) begin
      errors++;
      $display("FAIL abort_pulse got abort=%b csb=%b busy=%b done=%b want 1/1/0/0",
               bus.ABORT, bus.CSB, bus.BUSY, bus.DONE);
    end
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (bus.ABORT !== 1'b0) begin
      errors++;
      $display("FAIL abort_width got %b want 0", bus.ABORT);
    end
    clear_obs();
    send_header(16'd5, 1'b0);
    send_data(5);
    model_writes(5);
    checks++;
    if (!writes_match() || csb_low_cnt != 5) begin
      errors++;
      $display("FAIL abort_restart got writes=%0d csb_low=%0d want 5/5 from addr 0",
               obs_q.size(), csb_low_cnt);
    end
    go_hunt();
  endtask

  task automatic test_tap_reset();
    send_header(16'd4, 1'b0);
    send_data(1);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    checks++;
    if (bus.ABORT !== 1'b1 || bus.BUSY !== 1'b0 || bus.CSB !== 1'b1) begin
      errors++;
      $display("FAIL tap_reset_xfer got abort=%b busy=%b csb=%b want 1/0/1", bus.ABORT, bus.BUSY, bus.CSB);
    end
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    send_header(16'd0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (bus.DONE !== 1'b0 || bus.ABORT !== 1'b0) begin
      errors++;
      $display("FAIL tap_reset_done got done=%b abort=%b want 0/0", bus.DONE, bus.ABORT);
    end
    send_header(16'd6, 1'b1);
    checks++;
    if (bus.BUSY !== 1'b0 || bus.DONE !== 1'b0 || bus.CSB !== 1'b1 || bus.ABORT !== 1'b0) begin
      errors++;
      $display("FAIL tap_reset_wins got busy=%b done=%b csb=%b abort=%b want 0/0/1/0",
               bus.BUSY, bus.DONE, bus.CSB, bus.ABORT);
    end
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_async_reset();
    send_header(16'd10, 1'b0);
    send_data(3);
    #3 RESET_N = 1'b0;
    #1;
    checks++;
    if (bus.CSB !== 1'b1) begin
      errors++;
      $display("FAIL async_csb got %b want 1", bus.CSB);
    end
    checks++;
    if ({bus.WR_EN, bus.BUSY, bus.DONE, bus.LEN_ERR, bus.ABORT} !== 5'b0 ||
        bus.WR_ADDR !== '0 || bus.LEN !== 16'd0) begin
      errors++;
      $display("FAIL async_outputs got we=%b busy=%b done=%b err=%b abort=%b addr=%0d len=%0d want all 0",
               bus.WR_EN, bus.BUSY, bus.DONE, bus.LEN_ERR, bus.ABORT, bus.WR_ADDR, bus.LEN);
    end
    #2 RESET_N = 1'b1;
    clear_obs();
    send_data(10);
    checks++;
    if (csb_low_cnt != 0 || obs_q.size() != 0 || bus.BUSY !== 1'b0) begin
      errors++;
      $display("FAIL no_resume got csb_low=%0d writes=%0d busy=%b want 0/0/0",
               csb_low_cnt, obs_q.size(), bus.BUSY);
    end
  endtask

  task automatic test_back_to_back();
    int len;
    for (int t = 0; t < 4; t++) begin
      len = $urandom_range(1, 40);
      repeat ($urandom_range(0, 4)) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      clear_obs();
      send_header(16'(len), 1'b0);
      send_data(len + $urandom_range(0, 3));
      model_writes(len);
      checks++;
      if (csb_low_cnt != model_bits(len) || !writes_match() || bus.DONE !== 1'b1 || bus.LEN !== 16'(len)) begin
        errors++;
        $display("FAIL b2b_%0d got csb_low=%0d writes=%0d done=%b len=%0d want %0d/%0d/1/%0d",
                 t, csb_low_cnt, obs_q.size(), bus.DONE, bus.LEN, len, len, len);
      end
      go_hunt();
    end
  endtask

  task automatic test_mosi();
    checks++;
    if (mosi_err != 0) begin
      errors++;
      $display("FAIL mosi_copy got %0d differing shift cycles want 0", mosi_err);
    end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    checks = 0;
    errors = 0;
    mosi_err = 0;
    pause_bad = 0;
    csb_low_cnt = 0;
    RESET_N = 1'b0;
    bus.SEL1 = 1'b0;
    bus.SHIFT = 1'b0;
    bus.CAPTURE = 1'b0;
    bus.TAP_RESET = 1'b0;
    bus.TDI = 1'b0;
    repeat (3) @(posedge DRCK1);
    #1;
    test_reset();
    RESET_N = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    test_basic();
    test_zero_len();
    test_clamp();
    test_pause();
    test_abort();
    test_tap_reset();
    test_async_reset();
    test_back_to_back();
    test_mosi();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
